// File: rtl/bp_axil_mmio_out_buffer.sv
// AXI4-Lite responder that queues BP MMIO out-commands as (addr, data) pairs
// and lets the host poll them word by word: 0x8 gives the word count, 0xC pops.
module bp_axil_mmio_out_buffer #(
    parameter int S_AXIL_ADDR_WIDTH = 64,
    parameter int S_AXIL_DATA_WIDTH = 32,
    parameter int ELS_P             = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_i,

    input  logic                           mmio_v_i,
    input  logic [31:0]                    mmio_addr_i,
    input  logic [31:0]                    mmio_data_i,
    output logic                           mmio_ready_and_o,

    input  logic [S_AXIL_ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic                           s_axil_arvalid,
    output logic                           s_axil_arready,
    input  logic [2:0]                     s_axil_arprot,
    output logic [S_AXIL_DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]                     s_axil_rresp,
    output logic                           s_axil_rvalid,
    input  logic                           s_axil_rready,

    input  logic [S_AXIL_ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                           s_axil_awvalid,
    output logic                           s_axil_awready,
    input  logic [2:0]                     s_axil_awprot,
    input  logic [S_AXIL_DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [S_AXIL_DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                           s_axil_wvalid,
    output logic                           s_axil_wready,
    output logic [1:0]                     s_axil_bresp,
    output logic                           s_axil_bvalid,
    input  logic                           s_axil_bready
);

    localparam int PTR_W = $clog2(ELS_P);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [0:0] e_ar_idle = 1'b0;
    localparam logic [0:0] e_r_resp  = 1'b1;

    logic [63:0]      mem [ELS_P];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   occ_r;
    logic             rd_half_r;
    logic [0:0]       state_r;

    logic             enq;
    logic             ar_hs;
    logic             is_cnt;
    logic             is_pop;
    logic             not_empty;
    logic             pop_word;
    logic             deq;
    logic [63:0]      head;
    logic [PTR_W+1:0] cnt_w;
    logic [31:0]      word_cnt;
    logic [31:0]      rdata_n;
    logic [1:0]       rresp_n;
    logic [31:0]      rdata_r;
    logic [1:0]       rresp_r;

    assign mmio_ready_and_o = (occ_r != (PTR_W+1)'(ELS_P));
    assign enq              = mmio_v_i & mmio_ready_and_o;

    assign s_axil_arready = (state_r == e_ar_idle);
    assign s_axil_rvalid  = (state_r == e_r_resp);
    assign ar_hs          = s_axil_arvalid & s_axil_arready;

    assign is_cnt    = (s_axil_araddr[7:0] == 8'h08);
    assign is_pop    = (s_axil_araddr[7:0] == 8'h0C);
    assign not_empty = (occ_r != '0);
    assign pop_word  = ar_hs & is_pop & not_empty;
    assign deq       = pop_word & rd_half_r;

    assign head     = mem[rd_ptr_r];
    assign cnt_w    = {occ_r, 1'b0} - (PTR_W+2)'(rd_half_r);
    assign word_cnt = 32'(cnt_w);

    always_comb begin
        rdata_n = '0;
        rresp_n = RESP_SLVERR;
        unique case (1'b1)
            is_cnt: begin
                rdata_n = word_cnt;
                rresp_n = RESP_OKAY;
            end
            is_pop: begin
                rresp_n = RESP_OKAY;
                if (not_empty)
                    rdata_n = rd_half_r ? head[63:32] : head[31:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= e_ar_idle;
            rdata_r <= '0;
            rresp_r <= RESP_OKAY;
        end else begin
            unique case (state_r)
                e_ar_idle: if (ar_hs) begin
                    state_r <= e_r_resp;
                    rdata_r <= rdata_n;
                    rresp_r <= rresp_n;
                end
                e_r_resp: if (s_axil_rready)
                    state_r <= e_ar_idle;
                default: state_r <= e_ar_idle;
            endcase
        end
    end

    assign s_axil_rdata = S_AXIL_DATA_WIDTH'(rdata_r);
    assign s_axil_rresp = rresp_r;

    // The pop commits at AR acceptance, not when the host takes the R beat.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            occ_r     <= '0;
            rd_half_r <= 1'b0;
        end else begin
            if (enq)
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_word) begin
                if (rd_half_r) begin
                    rd_ptr_r  <= rd_ptr_r + PTR_W'(1);
                    rd_half_r <= 1'b0;
                end else begin
                    rd_half_r <= 1'b1;
                end
            end
            unique case ({enq, deq})
                2'b10:   occ_r <= occ_r + (PTR_W+1)'(1);
                2'b01:   occ_r <= occ_r - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq)
            mem[wr_ptr_r] <= {mmio_data_i, mmio_addr_i};
    end

    logic aw_got_r;
    logic w_got_r;
    logic bvalid_r;
    logic aw_hs;
    logic w_hs;

    assign s_axil_awready = ~aw_got_r;
    assign s_axil_wready  = ~w_got_r;
    assign aw_hs          = s_axil_awvalid & s_axil_awready;
    assign w_hs           = s_axil_wvalid & s_axil_wready;
    assign s_axil_bvalid  = bvalid_r;
    assign s_axil_bresp   = RESP_SLVERR;

    // Writes are only acknowledged with an error; they never touch the FIFO.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            aw_got_r <= 1'b0;
            w_got_r  <= 1'b0;
            bvalid_r <= 1'b0;
        end else if (bvalid_r) begin
            if (s_axil_bready) begin
                bvalid_r <= 1'b0;
                aw_got_r <= 1'b0;
                w_got_r  <= 1'b0;
            end
        end else begin
            aw_got_r <= aw_got_r | aw_hs;
            w_got_r  <= w_got_r | w_hs;
            bvalid_r <= (aw_got_r | aw_hs) & (w_got_r | w_hs);
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{s_axil_araddr[S_AXIL_ADDR_WIDTH-1:8],
                             s_axil_arprot, s_axil_awaddr, s_axil_awprot,
                             s_axil_wdata, s_axil_wstrb};

`ifndef SYNTHESIS
    a_data_width: assert property (@(posedge clk_i)
        S_AXIL_DATA_WIDTH == 32);

    a_r_stable: assert property (@(posedge clk_i) disable iff (reset_i)
        s_axil_rvalid && !s_axil_rready
        |=> $stable(s_axil_rdata) && $stable(s_axil_rresp));
`endif

endmodule

// File: tb/tb_bp_axil_mmio_out_buffer.sv
// Randomised bench for bp_axil_mmio_out_buffer: a word-queue reference model
// feeds a scoreboard that a negedge monitor drains on each R beat.
module tb_bp_axil_mmio_out_buffer;

    localparam int ELS = 16;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        mmio_v_i = 1'b0;
    logic [31:0] mmio_addr_i = '0;
    logic [31:0] mmio_data_i = '0;
    logic        mmio_ready_and_o;
    logic [63:0] s_axil_araddr = '0;
    logic        s_axil_arvalid = 1'b0;
    logic        s_axil_arready;
    logic [2:0]  s_axil_arprot = '0;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready = 1'b0;
    logic [63:0] s_axil_awaddr = '0;
    logic        s_axil_awvalid = 1'b0;
    logic        s_axil_awready;
    logic [2:0]  s_axil_awprot = '0;
    logic [31:0] s_axil_wdata = '0;
    logic [3:0]  s_axil_wstrb = '0;
    logic        s_axil_wvalid = 1'b0;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready = 1'b0;

    bp_axil_mmio_out_buffer #(
        .S_AXIL_ADDR_WIDTH(64),
        .S_AXIL_DATA_WIDTH(32),
        .ELS_P(ELS)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .mmio_v_i(mmio_v_i),
        .mmio_addr_i(mmio_addr_i),
        .mmio_data_i(mmio_data_i),
        .mmio_ready_and_o(mmio_ready_and_o),
        .s_axil_araddr(s_axil_araddr),
        .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready),
        .s_axil_arprot(s_axil_arprot),
        .s_axil_rdata(s_axil_rdata),
        .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid),
        .s_axil_rready(s_axil_rready),
        .s_axil_awaddr(s_axil_awaddr),
        .s_axil_awvalid(s_axil_awvalid),
        .s_axil_awready(s_axil_awready),
        .s_axil_awprot(s_axil_awprot),
        .s_axil_wdata(s_axil_wdata),
        .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp),
        .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is a flat queue of 32-bit words.
    logic [31:0] words[$];
    logic [31:0] exp_d[$];
    logic [1:0]  exp_r[$];
    bit          out_m = 0;
    bit          started = 0;
    bit          held_v = 0;
    logic [31:0] held_d;
    logic [1:0]  held_r;

    function automatic bit model_ready();
        return ((words.size() + 1) / 2) != ELS;
    endfunction

    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            words.delete();
            exp_d.delete();
            exp_r.delete();
            out_m = 0;
            held_v = 0;
        end else begin
            bit rdy;
            bit hs;
            rdy = model_ready();
            hs = !out_m && s_axil_arvalid;
            if (out_m && s_axil_rready)
                out_m = 0;
            if (hs) begin
                if (s_axil_araddr[7:0] == 8'h08) begin
                    exp_d.push_back(32'(words.size()));
                    exp_r.push_back(2'b00);
                end else if (s_axil_araddr[7:0] == 8'h0C) begin
                    exp_d.push_back(words.size() != 0 ? words.pop_front() : 32'h0);
                    exp_r.push_back(2'b00);
                end else begin
                    exp_d.push_back(32'h0);
                    exp_r.push_back(2'b10);
                end
                out_m = 1;
            end
            if (mmio_v_i && rdy) begin
                words.push_back(mmio_addr_i);
                words.push_back(mmio_data_i);
            end
        end
    end

    always @(negedge clk_i) begin
        if (started && !reset_i) begin
            check("rvalid", s_axil_rvalid, out_m);
            check("arready", s_axil_arready, !out_m);
            check("mmio_ready", mmio_ready_and_o, model_ready());
            if (s_axil_rvalid) begin
                if (held_v) begin
                    check("rdata_stable", s_axil_rdata, held_d);
                    check("rresp_stable", s_axil_rresp, held_r);
                end
                if (s_axil_rready) begin
                    held_v = 0;
                    if (exp_d.size() == 0) begin
                        check("r_unexpected", 1, 0);
                    end else begin
                        check("rdata", s_axil_rdata, exp_d.pop_front());
                        check("rresp", s_axil_rresp, exp_r.pop_front());
                    end
                end else begin
                    held_v = 1;
                    held_d = s_axil_rdata;
                    held_r = s_axil_rresp;
                end
            end else begin
                held_v = 0;
            end
        end
    end

    bit          rnd_en = 0;
    int          rate = 0;
    bit          dir_req = 0;
    logic [31:0] dir_addr;
    logic [31:0] dir_data;

    always @(posedge clk_i) begin
        #1;
        if (dir_req) begin
            mmio_v_i = 1'b1;
            mmio_addr_i = dir_addr;
            mmio_data_i = dir_data;
            dir_req = 0;
        end else if (rnd_en && $urandom_range(99) < rate) begin
            mmio_v_i = 1'b1;
            mmio_addr_i = $urandom();
            mmio_data_i = $urandom();
        end else begin
            mmio_v_i = 1'b0;
        end
    end

    task automatic enq(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk_i);
        dir_addr = a;
        dir_data = d;
        dir_req = 1;
        @(negedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_read(input logic [7:0] lo, input int hold);
        logic [63:0] a;
        bit ok;
        a = {$urandom(), $urandom()};
        a[7:0] = lo;
        @(posedge clk_i);
        #1;
        s_axil_araddr = a;
        s_axil_arvalid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (s_axil_arready) begin
                ok = 1;
                break;
            end
        end
        check("ar_accept_timeout", ok, 1);
        @(posedge clk_i);
        #1;
        s_axil_arvalid = 1'b0;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (s_axil_rvalid) begin
                ok = 1;
                break;
            end
        end
        check("rvalid_timeout", ok, 1);
        repeat (hold) @(posedge clk_i);
        @(posedge clk_i);
        #1;
        s_axil_rready = 1'b1;
        @(posedge clk_i);
        #1;
        s_axil_rready = 1'b0;
    endtask

    task automatic wait_sig(input string name, ref logic sig);
        bit ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (sig) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] addrs[8];
    int bcnt;

    initial begin
        addrs = '{8'h08, 8'h0C, 8'h0C, 8'h0C, 8'h00, 8'h04, 8'h10, 8'hFF};
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        check("rst_rvalid", s_axil_rvalid, 0);
        check("rst_rdata", s_axil_rdata, 0);
        check("rst_rresp", s_axil_rresp, 0);
        check("rst_arready", s_axil_arready, 1);
        check("rst_awready", s_axil_awready, 1);
        check("rst_wready", s_axil_wready, 1);
        check("rst_bvalid", s_axil_bvalid, 0);
        check("rst_mmio_ready", mmio_ready_and_o, 1);
        started = 1;

        do_read(8'h08, 0);

        enq(32'h0010_1000, 32'h41);
        do_read(8'h08, 0);
        do_read(8'h0C, 1);
        do_read(8'h0C, 0);
        do_read(8'h08, 0);

        // Fill to capacity, then pop a pair while the producer keeps pushing.
        rate = 100;
        rnd_en = 1;
        repeat (40) @(posedge clk_i);
        @(negedge clk_i);
        check("full_ready_low", mmio_ready_and_o, 0);
        check("full_count_model", 32'(words.size()), 32);
        do_read(8'h08, 0);
        do_read(8'h0C, 0);
        do_read(8'h0C, 0);
        @(negedge clk_i);
        rnd_en = 0;
        repeat (3) @(posedge clk_i);
        do_read(8'h08, 0);
        rnd_en = 0;
        @(negedge clk_i);
        do_read(8'h0C, 0);
        do_read(8'h0C, 0);
        @(negedge clk_i);
        check("ready_after_pair_pop", mmio_ready_and_o, 1);
        while (words.size() != 0) do_read(8'h0C, 0);

        enq(32'hA000_0000, 32'h1);
        enq(32'hA000_0004, 32'h2);
        do_read(8'h0C, 0);
        do_read(8'h08, 0);
        @(negedge clk_i);
        dir_addr = 32'hA000_0008;
        dir_data = 32'h3;
        dir_req = 1;
        do_read(8'h0C, 0);
        do_read(8'h08, 0);
        check("split_count_model", 32'(words.size()), 4);
        while (words.size() != 0) do_read(8'h0C, 0);

        do_read(8'h0C, 0);
        do_read(8'h10, 5);
        do_read(8'h08, 0);

        // W beat first, then AW; exactly one error response expected.
        @(posedge clk_i);
        #1;
        s_axil_wdata = $urandom();
        s_axil_wstrb = 4'hF;
        s_axil_wvalid = 1'b1;
        wait_sig("w_accept_timeout", s_axil_wready);
        @(posedge clk_i);
        #1 s_axil_wvalid = 1'b0;
        @(negedge clk_i);
        check("w_only_wready", s_axil_wready, 0);
        check("w_only_awready", s_axil_awready, 1);
        check("w_only_bvalid", s_axil_bvalid, 0);
        @(posedge clk_i);
        #1;
        s_axil_awaddr = {$urandom(), $urandom()};
        s_axil_awvalid = 1'b1;
        wait_sig("aw_accept_timeout", s_axil_awready);
        @(posedge clk_i);
        #1 s_axil_awvalid = 1'b0;
        wait_sig("bvalid_timeout", s_axil_bvalid);
        check("bresp", s_axil_bresp, 2'b10);
        check("b_pending_awready", s_axil_awready, 0);
        @(posedge clk_i);
        #1 s_axil_bready = 1'b1;
        bcnt = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (s_axil_bvalid) bcnt++;
        end
        check("b_beats", bcnt, 1);
        s_axil_bready = 1'b0;
        check("post_b_awready", s_axil_awready, 1);
        check("post_b_wready", s_axil_wready, 1);
        do_read(8'h08, 0);

        // Reset while an R beat is waiting.
        enq(32'hB000_0000, 32'hB1);
        @(posedge clk_i);
        #1;
        s_axil_araddr = 64'h0C;
        s_axil_arvalid = 1'b1;
        wait_sig("ar_rst_timeout", s_axil_arready);
        @(posedge clk_i);
        #1 s_axil_arvalid = 1'b0;
        @(negedge clk_i);
        check("pre_rst_rvalid", s_axil_rvalid, 1);
        @(posedge clk_i);
        #1 reset_i = 1'b1;
        #1 check("rst_rvalid_drop", s_axil_rvalid, 0);
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
        do_read(8'h08, 0);

        rate = 40;
        rnd_en = 1;
        for (int i = 0; i < 150; i++)
            do_read(addrs[$urandom_range(7)], $urandom_range(2));
        @(negedge clk_i);
        rnd_en = 0;
        repeat (3) @(posedge clk_i);
        do_read(8'h08, 0);
        repeat (3) @(negedge clk_i);
        check("scoreboard_drain", 32'(exp_d.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
